mdu_ctrl: RTL

- Multiply/divide unit with its sequencing controller for the 5-stage pipeline.
- Sits in the E stage and owns the HI/LO registers.
- Accepts mult/div/mthi/mtlo from E, runs a fixed-latency busy counter, and produces the stall request that freezes the F/D and D/E pipeline registers while a decoded HI/LO-related instruction would conflict.

---
 rtl/mdu_if.sv | 22 ++
 rtl/mdu_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mdu_if.sv
// E-stage <-> MDU bundle: command/operands from the pipeline, HI/LO, busy and stall back.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_D;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    modport master (
        output start, op, a, b, md_use_D,
        input  hi, lo, busy, stall_req
    );

    modport slave (
        input  start, op, a, b, md_use_D,
        output hi, lo, busy, stall_req
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit for the E stage: owns HI/LO, models a fixed busy latency
// and raises the stall request when a D-stage HI/LO instruction would collide.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  mdu
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_pend_hi;
    logic [31:0]   r_pend_lo;
    logic          r_pend_we;

    logic          w_busy;
    logic          w_is_arith;
    logic [63:0]   w_prod_s;
    logic [63:0]   w_prod_u;
    logic          w_div_ovf;
    logic [31:0]   w_bs;
    logic [31:0]   w_bu;
    logic [31:0]   w_quot_s;
    logic [31:0]   w_rem_s;
    logic [31:0]   w_quot_u;
    logic [31:0]   w_rem_u;
    logic [31:0]   w_new_hi;
    logic [31:0]   w_new_lo;
    logic          w_new_we;
    logic [CW-1:0] w_load;

    // A zero divisor is replaced by 1 so simulation never sees x; the write is
    // suppressed anyway. MIN/-1 is divided by 1 instead, which yields exactly
    // quotient MIN and remainder 0 without overflowing the divider.
    always_comb begin
        w_prod_s  = $signed({{32{mdu.a[31]}}, mdu.a}) * $signed({{32{mdu.b[31]}}, mdu.b});
        w_prod_u  = {32'd0, mdu.a} * {32'd0, mdu.b};
        w_div_ovf = (mdu.a == 32'h8000_0000) && (mdu.b == 32'hFFFF_FFFF);
        w_bs      = ((mdu.b == 32'd0) || w_div_ovf) ? 32'd1 : mdu.b;
        w_bu      = (mdu.b == 32'd0) ? 32'd1 : mdu.b;
        w_quot_s  = $signed(mdu.a) / $signed(w_bs);
        w_rem_s   = $signed(mdu.a) % $signed(w_bs);
        w_quot_u  = mdu.a / w_bu;
        w_rem_u   = mdu.a % w_bu;

        w_is_arith = 1'b0;
        w_new_hi   = 32'd0;
        w_new_lo   = 32'd0;
        w_new_we   = 1'b0;
        w_load     = '0;
        case (mdu.op)
            OP_MULT: begin
                w_is_arith = 1'b1;
                w_new_hi   = w_prod_s[63:32];
                w_new_lo   = w_prod_s[31:0];
                w_new_we   = 1'b1;
                w_load     = CW'(MULT_CYCLES);
            end
            OP_MULTU: begin
                w_is_arith = 1'b1;
                w_new_hi   = w_prod_u[63:32];
                w_new_lo   = w_prod_u[31:0];
                w_new_we   = 1'b1;
                w_load     = CW'(MULT_CYCLES);
            end
            OP_DIV: begin
                w_is_arith = 1'b1;
                w_new_hi   = w_rem_s;
                w_new_lo   = w_quot_s;
                w_new_we   = (mdu.b != 32'd0);
                w_load     = CW'(DIV_CYCLES);
            end
            OP_DIVU: begin
                w_is_arith = 1'b1;
                w_new_hi   = w_rem_u;
                w_new_lo   = w_quot_u;
                w_new_we   = (mdu.b != 32'd0);
                w_load     = CW'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    // While counting, new commands are ignored; HI/LO only change on the final
    // count edge or on an MTHI/MTLO accepted while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else if (r_cnt != '0) begin
            if (r_cnt == CW'(1)) begin
                if (r_pend_we) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end else if (mdu.start) begin
            if (w_is_arith) begin
                r_pend_hi <= w_new_hi;
                r_pend_lo <= w_new_lo;
                r_pend_we <= w_new_we;
                r_cnt     <= w_load;
            end else if (mdu.op == OP_MTHI) begin
                r_hi <= mdu.a;
            end else if (mdu.op == OP_MTLO) begin
                r_lo <= mdu.a;
            end
        end
    end

    assign w_busy        = (r_cnt != '0);
    assign mdu.busy      = w_busy;
    assign mdu.hi        = r_hi;
    assign mdu.lo        = r_lo;
    assign mdu.stall_req = reset & mdu.md_use_D & (w_busy | (mdu.start & w_is_arith));

endmodule
